// File: rtl/data_mem_responder_pkg.sv
// Shared types and decode helpers for the data-memory responder.
package data_mem_responder_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_t;

    // Request is rejected for bad size codes, unsigned stores, misalignment or out-of-range address.
    function automatic logic mem_req_err(input logic        we,
                                         input logic [2:0]  funct3,
                                         input logic [31:0] addr,
                                         input logic [31:0] limit);
        logic bad;
        case (funct3)
            MEM_B, MEM_BU: bad = 1'b0;
            MEM_H, MEM_HU: bad = addr[0];
            MEM_W:         bad = |addr[1:0];
            default:       bad = 1'b1;
        endcase
        if (we && funct3[2]) bad = 1'b1;
        if (addr >= limit) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] mem_byte_en(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3)
            MEM_B, MEM_BU: be = 4'b0001 << off;
            MEM_H, MEM_HU: be = 4'b0011 << off;
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core load/store path and the data-memory responder.
interface data_mem_responder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [WIDTH-1:0] req_addr;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/byte_enable_ram.sv
// Single-port word RAM with per-byte write enables; synchronous read and write, no reset.
module byte_enable_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [3:0]                     be_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits WAIT_CYCLES, accesses the RAM and
// returns a one-cycle registered response.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus_io
);
    localparam int unsigned      AW        = $clog2(DEPTH_WORDS);
    localparam logic [WIDTH-1:0] ByteLimit = WIDTH'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic             we_q;
    logic [AW+1:0]    addr_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] wdata_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_rdata_q;
    logic             rsp_err_q;

    logic [AW-1:0]    ram_addr;
    logic [3:0]       ram_be;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] load_data;
    logic             req_err;

    assign req_err = mem_req_err(bus_io.req_we, bus_io.req_funct3, bus_io.req_addr, ByteLimit);

    // Address the RAM with the incoming request while idle so the word is ready in ACCESS.
    assign ram_addr  = (state_q == StIdle) ? bus_io.req_addr[AW+1:2] : addr_q[AW+1:2];
    assign ram_be    = (state_q == StAccess && we_q) ? mem_byte_en(funct3_q, addr_q[1:0]) : 4'b0;
    assign ram_wdata = wdata_q << {addr_q[1:0], 3'b000};

    byte_enable_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i  (clk),
        .addr_i (ram_addr),
        .be_i   (ram_be),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        lane = ram_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            MEM_B:   load_data = {{24{lane[7]}}, lane[7:0]};
            MEM_H:   load_data = {{16{lane[15]}}, lane[15:0]};
            MEM_BU:  load_data = {24'b0, lane[7:0]};
            MEM_HU:  load_data = {16'b0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            funct3_q    <= 3'b0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.req_valid) begin
                        we_q        <= bus_io.req_we;
                        addr_q      <= bus_io.req_addr[AW+1:0];
                        funct3_q    <= bus_io.req_funct3;
                        wdata_q     <= bus_io.req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (WAIT_CYCLES > 0) begin
                            state_q <= StWait;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) state_q <= StAccess;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                StAccess: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= we_q ? '0 : load_data;
                end
                StResp: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus_io.req_ready = req_ready_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vectors plus random traffic against a byte-level model,
// on one instance with no wait states and one with three.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst0 = 1'b1;
    logic        rst3 = 1'b1;
    logic        v0 = 1'b0;
    logic        v3 = 1'b0;
    logic        t_we = 1'b0;
    logic [2:0]  t_f3 = 3'b0;
    logic [31:0] t_addr = 32'b0;
    logic [31:0] t_wd = 32'b0;
    bit          cur = 1'b0;
    logic        m_rdy, m_rv, m_err;
    logic [31:0] m_rdata;

    int    total = 0;
    int    bad = 0;
    string tag = "";

    logic [7:0] mm [2][4096];
    bit         kn [2][4096];

    data_mem_responder_if #(.WIDTH(32)) b0 ();
    data_mem_responder_if #(.WIDTH(32)) b3 ();

    assign b0.req_valid  = v0;
    assign b0.req_we     = t_we;
    assign b0.req_addr   = t_addr;
    assign b0.req_funct3 = t_f3;
    assign b0.req_wdata  = t_wd;
    assign b3.req_valid  = v3;
    assign b3.req_we     = t_we;
    assign b3.req_addr   = t_addr;
    assign b3.req_funct3 = t_f3;
    assign b3.req_wdata  = t_wd;

    data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst   (rst0),
        .bus_io(b0)
    );

    data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
        .clk   (clk),
        .rst   (rst3),
        .bus_io(b3)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_rdy   = cur ? b3.req_ready : b0.req_ready;
        m_rv    = cur ? b3.rsp_valid : b0.rsp_valid;
        m_err   = cur ? b3.rsp_err   : b0.rsp_err;
        m_rdata = cur ? b3.rsp_rdata : b0.rsp_rdata;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s [%s] got=%h want=%h", nm, tag, got, exp);
        end
    endtask

    // Byte-addressed reference: sizes, alignment and extension from plain arithmetic.
    function automatic void model(input int s, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er, output bit known);
        int sz;
        bit sgn;
        sz = 0;
        sgn = 1'b0;
        case (f3)
            3'd0: begin sz = 1; sgn = 1'b1; end
            3'd1: begin sz = 2; sgn = 1'b1; end
            3'd2: sz = 4;
            3'd4: sz = 1;
            3'd5: sz = 2;
            default: sz = 0;
        endcase
        rd = 32'b0;
        known = 1'b1;
        er = (sz == 0) || (we && (f3 == 3'd4 || f3 == 3'd5)) || (a >= 32'd4096);
        if (!er && (a % sz) != 0) er = 1'b1;
        if (er) return;
        for (int i = 0; i < sz; i++) begin
            int ai;
            ai = int'(a) + i;
            if (we) begin
                mm[s][ai] = wd[8*i +: 8];
                kn[s][ai] = 1'b1;
            end else begin
                rd = rd | (32'(mm[s][ai]) << (8 * i));
                known = known & kn[s][ai];
            end
        end
        if (!we && sgn && sz < 4 && rd[8*sz-1]) rd = rd | (32'hFFFF_FFFF << (8 * sz));
    endfunction

    task automatic txn(input bit s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er,
                       input int exp_lat, input bit chk_rd);
        logic rdy_bad;
        int   lat;
        @(negedge clk);
        cur = s;
        t_we = we;
        t_f3 = f3;
        t_addr = a;
        t_wd = wd;
        chk("ready_idle", {31'b0, m_rdy}, 32'd1);
        if (s) v3 = 1'b1;
        else   v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        v3 = 1'b0;
        lat = 1;
        rdy_bad = m_rdy;
        while (!m_rv && lat < 40) begin
            @(negedge clk);
            lat++;
            if (m_rdy) rdy_bad = 1'b1;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", {31'b0, m_err}, {31'b0, exp_er});
        if (chk_rd) chk("rdata", m_rdata, exp_rd);
        chk("ready_busy", {31'b0, rdy_bad}, 32'd0);
        @(negedge clk);
        chk("pulse_one", {31'b0, m_rv}, 32'd0);
        chk("err_hold", {31'b0, m_err}, {31'b0, exp_er});
        if (chk_rd) chk("rdata_hold", m_rdata, exp_rd);
    endtask

    task automatic run(input bit s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
        logic [31:0] erd;
        logic        eer;
        bit          known;
        model(int'(s), we, f3, a, wd, erd, eer, known);
        tag = $sformatf("s%0d we%0d f%0d a%h", s, we, f3, a);
        txn(s, we, f3, a, wd, erd, eer, eer ? 1 : (s ? 5 : 2), known);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] drd;
        logic        der;
        bit          dkn;
        int          lat;
        int          extra;

        tbl.push_back('{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd4, 32'h13,   32'h0,        32'h000000DE, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd1, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd5, 32'h12,   32'h0,        32'h0000DEAD, 1'b0, 2});
        tbl.push_back('{1'b1, 3'd1, 32'h12,   32'h00001234, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        32'h1234BEEF, 1'b0, 2});
        tbl.push_back('{1'b1, 3'd0, 32'h10,   32'h00000077, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        32'h1234BE77, 1'b0, 2});
        tbl.push_back('{1'b1, 3'd2, 32'h00,   32'h11223344, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 3'd2, 32'h02,   32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{1'b1, 3'd1, 32'h01,   32'h0000FFFF, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 3'd3, 32'h00,   32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{1'b1, 3'd0, 32'h1000, 32'h000000AA, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b1, 3'd4, 32'h00,   32'h000000AA, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 3'd2, 32'h00,   32'h0,        32'h11223344, 1'b0, 2});
        tbl.push_back('{1'b1, 3'd2, 32'hFFC,  32'hA5C3E10F, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 3'd1, 32'hFFE,  32'h0,        32'hFFFFA5C3, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd1, 32'h1000, 32'h0,        32'h0,        1'b1, 1});

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            cur = s[0];
            #1;
            tag = $sformatf("reset s%0d", s);
            chk("rst_ready", {31'b0, m_rdy}, 32'd1);
            chk("rst_valid", {31'b0, m_rv}, 32'd0);
            chk("rst_rdata", m_rdata, 32'd0);
            chk("rst_err", {31'b0, m_err}, 32'd0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;

        foreach (tbl[i]) begin
            model(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, drd, der, dkn);
            tag = $sformatf("vec%0d", i);
            txn(1'b0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].er,
                tbl[i].lat, 1'b1);
        end

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 64; w++) run(s[0], 1'b1, 3'd2, 32'(4 * w), $urandom);
        end

        // Wait-state instance: a valid pulsed while busy must be dropped, not queued.
        run(1'b1, 1'b1, 3'd2, 32'h24, 32'h600DCAFE);
        tag = "midwait";
        @(negedge clk);
        cur = 1'b1;
        t_we = 1'b0;
        t_f3 = 3'd2;
        t_addr = 32'h24;
        v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        lat = 1;
        @(negedge clk);
        lat++;
        t_addr = 32'h28;
        v3 = 1'b1;
        chk("midwait_ready", {31'b0, m_rdy}, 32'd0);
        @(negedge clk);
        lat++;
        v3 = 1'b0;
        while (!m_rv && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("midwait_lat", 32'(lat), 32'd5);
        chk("midwait_rdata", m_rdata, 32'h600DCAFE);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_rv) extra++;
        end
        chk("midwait_extra", 32'(extra), 32'd0);
        chk("midwait_idle", {31'b0, m_rdy}, 32'd1);

        // Reset during WAIT abandons the store.
        run(1'b1, 1'b1, 3'd2, 32'h20, 32'h5A5A1234);
        run(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        tag = "rst_wait";
        @(negedge clk);
        cur = 1'b1;
        t_we = 1'b1;
        t_f3 = 3'd2;
        t_addr = 32'h20;
        t_wd = 32'hCAFEF00D;
        v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        chk("rstw_ready", {31'b0, m_rdy}, 32'd1);
        chk("rstw_valid", {31'b0, m_rv}, 32'd0);
        chk("rstw_rdata", m_rdata, 32'd0);
        chk("rstw_err", {31'b0, m_err}, 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        run(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);

        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 200; n++) begin
                logic [31:0] a;
                int          r;
                r = $urandom_range(0, 9);
                if (r < 8)       a = 32'($urandom_range(0, 255));
                else if (r == 8) a = 32'($urandom_range(4088, 4103));
                else             a = $urandom;
                run(s[0], 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
